// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and address helpers for the APB completer
package apb_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} completer_state_e;

  localparam logic [2:0] PROT_DEFAULT = 3'b111;

  function automatic logic is_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

  function automatic logic [29:0] word_index(input logic [31:0] addr);
    return addr[31:2];
  endfunction

endpackage

// File: rtl/apb_if.sv
// rtl/apb_if.sv - APB4 bus bundle with requester and completer views
interface apb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [2:0]            pprot;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [3:0]            pstrb;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pprot, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pprot, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_regfile.sv
// rtl/apb_regfile.sv - word register file, byte-strobe write, registered read
module apb_regfile #(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  logic [31:0]      wdata,
  input  logic [3:0]       wstrb,
  input  logic             re,
  input  logic [IDX_W-1:0] ridx,
  output logic [31:0]      rdata
);

  logic [31:0] mem [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (wstrb[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
      end
      // Read data is zero outside a good read so prdata never leaks stale contents.
      rdata <= re ? mem[ridx] : '0;
    end
  end

endmodule

// File: rtl/apb_completer.sv
// rtl/apb_completer.sv - APB4 completer with wait states, protection check and error response
module apb_completer
  import apb_pkg::*;
#(
  parameter int         ADDR_WIDTH  = 32,
  parameter int         DATA_WIDTH  = 32,
  parameter int         NUM_REGS    = 16,
  parameter int         WAIT_STATES = 1,
  parameter int         PROT_BASE   = 8,
  parameter logic [2:0] PROT_REQ    = PROT_DEFAULT
) (
  input  logic       pclk,
  input  logic       preset,
  apb_if.slave       bus,
  output logic [7:0] err_count
);

  localparam int IDX_W = $clog2(NUM_REGS);

  completer_state_e state, nxt;

  logic [IDX_W-1:0] cap_idx;
  logic             cap_write;
  logic [31:0]      cap_wdata;
  logic [3:0]       cap_strb;
  logic             cap_err;
  logic [3:0]       wait_cnt;

  logic [31:0]      addr32;
  logic [29:0]      in_word;
  logic [IDX_W-1:0] in_idx;
  logic             in_err;

  logic             setup;
  logic             enter_done;
  logic [IDX_W-1:0] eff_idx;
  logic             eff_write;
  logic [31:0]      eff_wdata;
  logic [3:0]       eff_strb;
  logic             eff_err;
  logic             rf_we;
  logic             rf_re;
  logic             nxt_ready;
  logic             nxt_slverr;
  logic [31:0]      rf_rdata;

  assign addr32  = 32'(bus.paddr);
  assign in_word = word_index(addr32);
  assign in_idx  = in_word[IDX_W-1:0];
  assign in_err  = !is_aligned(addr32)
                || (in_word >= 30'(NUM_REGS))
                || ((in_word >= 30'(PROT_BASE)) && (bus.pprot != PROT_REQ));

  always_comb begin
    nxt   = state;
    setup = 1'b0;
    case (state)
      IDLE: begin
        if (bus.psel && !bus.penable)     setup = 1'b1;
        else if (bus.psel && bus.penable) nxt = ERR;
      end
      ACCESS: begin
        if (!bus.psel || !bus.penable) nxt = ERR;
        else if (wait_cnt <= 4'd1)     nxt = DONE;
      end
      DONE: begin
        if (bus.psel && !bus.penable) setup = 1'b1;
        else                          nxt = IDLE;
      end
      ERR:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (setup) nxt = (WAIT_STATES == 0) ? DONE : ACCESS;

    // With zero wait states the commit happens on the setup edge, before capture.
    eff_idx   = setup ? in_idx       : cap_idx;
    eff_write = setup ? bus.pwrite   : cap_write;
    eff_wdata = setup ? bus.pwdata   : cap_wdata;
    eff_strb  = setup ? bus.pstrb    : cap_strb;
    eff_err   = setup ? in_err       : cap_err;

    enter_done = (nxt == DONE);
    rf_we      = enter_done && eff_write && !eff_err;
    rf_re      = enter_done && !eff_write && !eff_err;
    nxt_ready  = (nxt == DONE) || (nxt == ERR);
    nxt_slverr = (nxt == ERR) || (enter_done && eff_err);
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state       <= IDLE;
      cap_idx     <= '0;
      cap_write   <= 1'b0;
      cap_wdata   <= '0;
      cap_strb    <= '0;
      cap_err     <= 1'b0;
      wait_cnt    <= '0;
      bus.pready  <= 1'b0;
      bus.pslverr <= 1'b0;
      err_count   <= '0;
    end else begin
      state <= nxt;
      if (setup) begin
        cap_idx   <= in_idx;
        cap_write <= bus.pwrite;
        cap_wdata <= bus.pwdata;
        cap_strb  <= bus.pstrb;
        cap_err   <= in_err;
        wait_cnt  <= 4'(WAIT_STATES);
      end else if (state == ACCESS && nxt == ACCESS) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      bus.pready  <= nxt_ready;
      bus.pslverr <= nxt_slverr;
      if (nxt_ready && nxt_slverr && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
    end
  end

  apb_regfile #(.NUM_REGS(NUM_REGS)) u_regfile (
    .clk   (pclk),
    .rst   (preset),
    .we    (rf_we),
    .widx  (eff_idx),
    .wdata (eff_wdata),
    .wstrb (eff_strb),
    .re    (rf_re),
    .ridx  (eff_idx),
    .rdata (rf_rdata)
  );

  assign bus.prdata = DATA_WIDTH'(rf_rdata);

endmodule

// File: tb/tb_apb_completer.sv
// tb/tb_apb_completer.sv - scoreboard bench for apb_completer at 1, 3 and 0 wait states
module tb_apb_completer;

  logic        pclk = 1'b0;
  logic        preset;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [2:0]  pprot;
  logic [3:0]  pstrb;
  int          dut_sel;

  always #5 pclk = ~pclk;

  apb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
  apb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();
  apb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus2 ();

  assign bus0.psel = psel && dut_sel == 0;
  assign bus1.psel = psel && dut_sel == 1;
  assign bus2.psel = psel && dut_sel == 2;
  assign bus0.penable = penable; assign bus1.penable = penable; assign bus2.penable = penable;
  assign bus0.pwrite  = pwrite;  assign bus1.pwrite  = pwrite;  assign bus2.pwrite  = pwrite;
  assign bus0.paddr   = paddr;   assign bus1.paddr   = paddr;   assign bus2.paddr   = paddr;
  assign bus0.pprot   = pprot;   assign bus1.pprot   = pprot;   assign bus2.pprot   = pprot;
  assign bus0.pwdata  = pwdata;  assign bus1.pwdata  = pwdata;  assign bus2.pwdata  = pwdata;
  assign bus0.pstrb   = pstrb;   assign bus1.pstrb   = pstrb;   assign bus2.pstrb   = pstrb;

  logic [7:0] ec0, ec1, ec2;

  apb_completer #(.WAIT_STATES(1)) dut0 (.pclk(pclk), .preset(preset), .bus(bus0), .err_count(ec0));
  apb_completer #(.WAIT_STATES(3)) dut1 (.pclk(pclk), .preset(preset), .bus(bus1), .err_count(ec1));
  apb_completer #(.WAIT_STATES(0)) dut2 (.pclk(pclk), .preset(preset), .bus(bus2), .err_count(ec2));

  logic        s_ready, s_slverr;
  logic [31:0] s_rdata;
  logic [7:0]  s_ec;

  always_comb begin
    s_ready = bus0.pready; s_slverr = bus0.pslverr; s_rdata = bus0.prdata; s_ec = ec0;
    if (dut_sel == 1) begin
      s_ready = bus1.pready; s_slverr = bus1.pslverr; s_rdata = bus1.prdata; s_ec = ec1;
    end else if (dut_sel == 2) begin
      s_ready = bus2.pready; s_slverr = bus2.pslverr; s_rdata = bus2.prdata; s_ec = ec2;
    end
  end

  typedef struct {
    logic        slverr;
    logic [31:0] rdata;
    int          cycles;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [3][16];
  int          exp_ec [3];
  int          ws [3] = '{1, 3, 0};
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 3; d++) begin
      exp_ec[d] = 0;
      for (int r = 0; r < 16; r++) model[d][r] = '0;
    end
  endtask

  task automatic xfer(input string tag, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s, input logic [2:0] p);
    exp_t e;
    int   idx;
    int   cyc;
    logic bad;
    idx = int'(a >> 2);
    bad = (a[1:0] != 2'b00) || ((a >> 2) >= 16) || (((a >> 2) >= 8) && p != 3'b111);
    e.slverr = bad;
    e.cycles = ws[dut_sel] + 1;
    e.rdata  = (w || bad) ? 32'h0 : model[dut_sel][idx];
    if (!bad && w)
      for (int b = 0; b < 4; b++)
        if (s[b]) model[dut_sel][idx][8*b +: 8] = d[8*b +: 8];
    if (bad && exp_ec[dut_sel] < 255) exp_ec[dut_sel]++;
    sb.push_back(e);

    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d; pstrb = s; pprot = p;
    @(posedge pclk); #1;
    penable = 1'b1;
    cyc = 1;
    @(negedge pclk);
    while (!s_ready && cyc < 40) begin
      @(negedge pclk);
      cyc++;
    end
    e = sb.pop_front();
    check({tag, " pready"}, 32'(s_ready), 32'h1);
    check({tag, " latency"}, cyc, e.cycles);
    check({tag, " pslverr"}, 32'(s_slverr), 32'(e.slverr));
    if (!w) check({tag, " prdata"}, s_rdata, e.rdata);
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge pclk);
    check({tag, " err_count"}, 32'(s_ec), exp_ec[dut_sel]);
  endtask

  task automatic drop_psel_read(input logic [31:0] a);
    exp_t e;
    int   cyc;
    e.slverr = 1'b1; e.rdata = 32'h0; e.cycles = 2;
    exp_ec[dut_sel]++;
    sb.push_back(e);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a; pprot = 3'b000;
    @(posedge pclk); #1;
    psel = 1'b0;
    cyc = 1;
    @(negedge pclk);
    while (!s_ready && cyc < 40) begin
      @(negedge pclk);
      cyc++;
    end
    e = sb.pop_front();
    check("drop latency", cyc, e.cycles);
    check("drop pslverr", 32'(s_slverr), 32'(e.slverr));
    check("drop prdata", s_rdata, e.rdata);
    @(negedge pclk);
    check("drop back to idle", 32'(s_ready), 32'h0);
    check("drop err_count", 32'(s_ec), exp_ec[dut_sel]);
  endtask

  initial begin
    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; pprot = '0; dut_sel = 0;
    clear_model();
    repeat (3) @(posedge pclk);
    #1 preset = 1'b0;
    @(negedge pclk);
    check("reset pready", 32'(bus0.pready), 32'h0);
    check("reset pslverr", 32'(bus0.pslverr), 32'h0);
    check("reset prdata", bus0.prdata, 32'h0);
    check("reset err_count", 32'(ec0), 32'h0);

    dut_sel = 0;
    xfer("w1 wr 0x4", 1'b1, 32'h4, 32'hDEADBEEF, 4'hF, 3'b000);
    xfer("w1 rd 0x4", 1'b0, 32'h4, 32'h0, 4'h0, 3'b000);
    xfer("w1 wr 0x8", 1'b1, 32'h8, 32'h11223344, 4'hF, 3'b000);
    xfer("w1 strb 0x8", 1'b1, 32'h8, 32'h000000AA, 4'b0001, 3'b000);
    xfer("w1 rd 0x8", 1'b0, 32'h8, 32'h0, 4'h0, 3'b000);
    xfer("w1 rd unaligned", 1'b0, 32'h3, 32'h0, 4'h0, 3'b000);
    xfer("w1 rd range", 1'b0, 32'h40, 32'h0, 4'h0, 3'b000);
    drop_psel_read(32'h4);
    xfer("w1 rd 0x4 after drop", 1'b0, 32'h4, 32'h0, 4'h0, 3'b000);
    xfer("prot wr 111", 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 3'b111);
    xfer("prot rd 111", 1'b0, 32'h20, 32'h0, 4'h0, 3'b111);
    xfer("prot wr 101", 1'b1, 32'h20, 32'h55555555, 4'hF, 3'b101);
    xfer("prot rd 011", 1'b0, 32'h20, 32'h0, 4'h0, 3'b011);
    xfer("prot rd kept", 1'b0, 32'h20, 32'h0, 4'h0, 3'b111);

    dut_sel = 1;
    xfer("w3 wr 0xC", 1'b1, 32'hC, 32'h0BADC0DE, 4'hF, 3'b000);
    xfer("w3 rd 0xC", 1'b0, 32'hC, 32'h0, 4'h0, 3'b000);

    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'hC; pwdata = 32'h12345678; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    preset = 1'b1; psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    preset = 1'b0;
    clear_model();
    @(negedge pclk);
    check("abort pready w3", 32'(bus1.pready), 32'h0);
    check("abort pready w1", 32'(bus0.pready), 32'h0);
    check("abort err_count w1", 32'(ec0), 32'h0);
    check("abort err_count w3", 32'(ec1), 32'h0);
    xfer("w3 rd 0xC after abort", 1'b0, 32'hC, 32'h0, 4'h0, 3'b000);
    xfer("w3 wr 0xC again", 1'b1, 32'hC, 32'hA5A5_5A5A, 4'b1010, 3'b000);
    xfer("w3 rd 0xC again", 1'b0, 32'hC, 32'h0, 4'h0, 3'b000);

    dut_sel = 2;
    xfer("w0 wr 0x4", 1'b1, 32'h4, 32'hDEADBEEF, 4'hF, 3'b000);
    xfer("w0 rd 0x4", 1'b0, 32'h4, 32'h0, 4'h0, 3'b000);
    xfer("w0 wr 0x8", 1'b1, 32'h8, 32'h11223344, 4'hF, 3'b000);
    xfer("w0 strb 0x8", 1'b1, 32'h8, 32'h000000AA, 4'b0001, 3'b000);
    xfer("w0 rd 0x8", 1'b0, 32'h8, 32'h0, 4'h0, 3'b000);
    xfer("w0 rd unaligned", 1'b0, 32'h3, 32'h0, 4'h0, 3'b000);
    xfer("w0 rd range", 1'b0, 32'h40, 32'h0, 4'h0, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_completer.md
Name: apb_completer

Overview:
- APB4 completer (responder) with a small word-addressed register file, configurable wait states, protection checking and error response.
- Sits behind the APB interface (completer side of apb_if) and answers the transfers that apb_bridge initiates.
- It is the first real DUT for the existing bench.

Parameters:
- ADDR_WIDTH, 32, paddr width.
- DATA_WIDTH, 32, pwdata/prdata width; must be 32 (byte strobes are 4 bits).
- NUM_REGS, 16, number of 32-bit registers, word index = paddr[5:2]; must be a power of 2.
- WAIT_STATES, 1, number of access cycles with pready low before completion; range 0..15.
- PROT_BASE, 8, first register index of the protected region (indices PROT_BASE..NUM_REGS-1).
- PROT_REQ, 3'b111, exact pprot value required to access the protected region.

Ports:
- pclk  in  1  APB clock.
- preset  in  1  synchronous, active-high reset.
- psel  in  1  completer select.
- penable  in  1  access phase.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_WIDTH  byte address.
- pprot  in  3  protection attributes.
- pwdata  in  DATA_WIDTH  write data.
- pstrb  in  4  write byte strobes.
- prdata  out  DATA_WIDTH  read data; valid when pready=1 and pslverr=0.
- pready  out  1  transfer completion.
- pslverr  out  1  error, valid only when pready=1.
- err_count  out  8  saturating count of error responses.

Behaviour:
- Reset is synchronous and active-high, sampled on posedge pclk. On reset:
  - pready=0, pslverr=0, prdata=0, err_count=0, all registers=0.
  - FSM goes to IDLE.
  - A reset mid-transfer aborts the transfer; no write commits.
- All outputs are registered; there is no combinational path from inputs to outputs.
- FSM states: IDLE, ACCESS, DONE, ERR.
- IDLE:
  - A sampled psel=1, penable=0 is the setup phase. Capture paddr, pwrite, pwdata, pstrb, pprot.
  - Evaluate the error condition: paddr[1:0]!=0, OR word index >= NUM_REGS (any paddr bit above [5:2] nonzero), OR (index >= PROT_BASE AND pprot != PROT_REQ).
  - Load wait_cnt=WAIT_STATES, then go to ACCESS. If WAIT_STATES==0, go directly to DONE, so pready is high in the first access cycle.
  - A sampled psel=1, penable=1 with no prior setup is a protocol error: go to ERR.
- ACCESS:
  - Each edge with psel=1, penable=1: decrement wait_cnt. When it reaches 0, go to DONE; pready rises in the next cycle.
  - An edge with psel=0 is an early deassertion: go to ERR.
  - penable=0 with psel=1 is also a protocol error: go to ERR.
- DONE (one cycle):
  - pready=1.
  - pslverr = the captured error flag.
  - Good read: prdata = reg[index]. Error read: prdata = 0.
  - Good write: commit at the edge entering DONE, per byte where pstrb[b]=1. Error write commits nothing.
  - Next state is IDLE. A back-to-back setup (psel=1, penable=0) sampled in the DONE cycle goes straight into the new transfer (ACCESS or DONE).
- ERR (one cycle): pready=1, pslverr=1, prdata=0, no write; then IDLE.
- err_count increments on each cycle with pready=1 and pslverr=1, and saturates at 8'hFF.
- Inputs changing mid-ACCESS are ignored; the captured values from setup are used.
- Reads of a register written in the immediately preceding transfer return the new value.

Decomposition:
- apb_pkg:
  - typedef enum for completer_state_e {IDLE, ACCESS, DONE, ERR}.
  - localparam PROT_DEFAULT=3'b111.
  - function is_aligned(addr).
  - function word_index(addr).
- Sub-module apb_regfile: NUM_REGS x 32 storage with a byte-strobe write port and a registered read port. The completer FSM owns all handshake logic.

Test Plan:
- Reset, then write 0xDEADBEEF to paddr 0x4 with pstrb=4'hF and pprot=0, then read 0x4. Required: pready high after exactly WAIT_STATES+1 access cycles, pslverr=0, prdata=0xDEADBEEF.
- Write 0x000000AA to 0x8 with pstrb=4'b0001 over prior value 0x11223344. Required: read of 0x8 returns 0x112233AA.
- Read unaligned paddr 0x3. Required: pready=1, pslverr=1, prdata=0, err_count=1. Read 0x40 (out of range): pslverr=1, err_count=2.
- Drop psel in the first access cycle of a read to 0x4. Required: one ERR cycle with pready=1 and pslverr=1, then the FSM returns to IDLE and the next valid read of 0x4 succeeds.
- Access index 8 (paddr 0x20):
  - pprot=3'b111 gives pslverr=0.
  - pprot=3'b101 and pprot=3'b011 give pslverr=1.
  - An errored write leaves reg[8] unchanged.
- Assert preset in the middle of a write to 0xC with WAIT_STATES=3. Required: pready=0, reg[3]=0, err_count=0; the next transfer completes normally. Repeat the directed reads with WAIT_STATES=0 and confirm single-cycle access.
